ahb_mem_slave: RTL

//  Parametrised, synthesizable AHB-Lite memory slave. Replaces the fixed, zero-wait behavioural memory model

---
 rtl/ahb_mem_slave_pkg.sv | 28 ++
 rtl/ahb_mem_slave_if.sv | 29 ++
 rtl/ahb_byte_lane_dec.sv | 32 +++
 rtl/ahb_mem_slave.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ahb_mem_slave_pkg.sv
// Shared codes, FSM state type and lane helper for the AHB-Lite memory slave.
// Imported by the interface, the lane decoder and the top.
package ahb_mem_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1
    } state_e;

    function automatic int lanes_of(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus bundle between one master and the memory slave.
// master drives address/control/write data; slave returns ready, response, read data.
interface ahb_mem_slave_if #(
    parameter int DATA_W = 32
);
    logic              HSEL_i;
    logic [31:0]       HADDR_i;
    logic [1:0]        HTRANS_i;
    logic              HWRITE_i;
    logic [2:0]        HSIZE_i;
    logic [2:0]        HBURST_i;
    logic [DATA_W-1:0] HWDATA_i;
    logic              HREADY_i;
    logic              HREADY_o;
    logic [1:0]        HRESP_o;
    logic [DATA_W-1:0] HRDATA_o;

    modport slave (
        input  HSEL_i, HADDR_i, HTRANS_i, HWRITE_i,
        input  HSIZE_i, HBURST_i, HWDATA_i, HREADY_i,
        output HREADY_o, HRESP_o, HRDATA_o
    );

    modport master (
        output HSEL_i, HADDR_i, HTRANS_i, HWRITE_i,
        output HSIZE_i, HBURST_i, HWDATA_i, HREADY_i,
        input  HREADY_o, HRESP_o, HRDATA_o
    );
endinterface

// File: rtl/ahb_byte_lane_dec.sv
// Combinational lane decoder: low address bits + HSIZE -> byte-lane mask,
// misalign flag and oversize flag. Ports: addr_lo_i, size_i, mask_o, misalign_o, oversize_o.
import ahb_mem_slave_pkg::*;

module ahb_byte_lane_dec #(
    parameter  int DATA_W = 32,
    localparam int LANES  = lanes_of(DATA_W),
    localparam int LB     = $clog2(LANES)
) (
    input  logic [LB-1:0]    addr_lo_i,
    input  logic [2:0]       size_i,
    output logic [LANES-1:0] mask_o,
    output logic             misalign_o,
    output logic             oversize_o
);

    always_comb begin
        automatic int lo = int'(addr_lo_i);
        automatic int nb = 1 << size_i;
        mask_o     = '0;
        misalign_o = 1'b0;
        // 8<<size > DATA_W is the same as size > log2(LANES)
        oversize_o = int'(size_i) > LB;
        for (int i = 0; i < LB; i++) begin
            if (i < int'(size_i)) misalign_o = misalign_o | addr_lo_i[i];
        end
        for (int i = 0; i < LANES; i++) begin
            mask_o[i] = !oversize_o && (i >= lo) && (i < lo + nb);
        end
    end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: base decode, wait states, byte strobes, two-cycle ERROR,
// saturating error counter, backdoor read. Ports: clk_i, rst_i, bus (slave), err_cnt_o, dbg_*.
import ahb_mem_slave_pkg::*;

module ahb_mem_slave #(
    parameter int          DATA_W      = 32,
    parameter int          MEM_BYTES   = 65536,
    parameter logic [31:0] BASE_ADDR   = 32'h0400_0000,
    parameter int          WAIT_STATES = 0,
    parameter bit          ERR_EN      = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ahb_mem_slave_if.slave    bus,
    output logic [15:0]       err_cnt_o,
    input  logic [31:0]       dbg_addr_i,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    localparam int LANES = lanes_of(DATA_W);
    localparam int LB    = $clog2(LANES);
    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WORDS = MEM_BYTES / LANES;

    logic [DATA_W-1:0] mem_q [WORDS];

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             wr_q, wr_d;
    logic             bad_q, bad_d;
    logic             err_q, err_d;
    logic [AW-1:0]    off_q, off_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic [15:0]      ecnt_q, ecnt_d;

    logic [31:0]      off_full;
    logic [LANES-1:0] lane_mask;
    logic             misalign, oversize;
    logic             accept, fin, bad_new;
    logic [DATA_W-1:0] rd_word;

    ahb_byte_lane_dec #(.DATA_W(DATA_W)) u_dec (
        .addr_lo_i  (bus.HADDR_i[LB-1:0]),
        .size_i     (bus.HSIZE_i),
        .mask_o     (lane_mask),
        .misalign_o (misalign),
        .oversize_o (oversize)
    );

    // unsigned wrap makes below-base addresses land out of range too
    assign off_full = bus.HADDR_i - BASE_ADDR;
    assign bad_new  = (off_full >= 32'(MEM_BYTES)) | misalign | oversize;
    assign accept   = bus.HSEL_i & bus.HREADY_i & bus.HTRANS_i[1] & bus.HREADY_o;
    assign fin      = (state_q == ST_IDLE) & pend_q;
    assign rd_word  = mem_q[off_q[AW-1:LB]];

    assign bus.HREADY_o = (state_q == ST_IDLE);
    assign bus.HRESP_o  = ((state_q == ST_ERR1) | (fin & err_q))
                        ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA_o = (fin & ~wr_q & ~bad_q) ? rd_word : '0;
    assign err_cnt_o    = ecnt_q;
    assign dbg_rdata_o  = mem_q[dbg_addr_i[AW-1:LB]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        err_d   = err_q;
        off_d   = off_q;
        mask_d  = mask_q;
        ecnt_d  = ecnt_q;
        unique case (state_q)
            ST_IDLE: begin
                pend_d = accept;
                if (accept) begin
                    wr_d   = bus.HWRITE_i;
                    bad_d  = bad_new;
                    err_d  = bad_new & ERR_EN;
                    off_d  = off_full[AW-1:0];
                    mask_d = lane_mask;
                    if (bad_new & ERR_EN) begin
                        state_d = ST_ERR1;
                        if (ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else cnt_d = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            off_q   <= '0;
            mask_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            off_q   <= off_d;
            mask_q  <= mask_d;
            ecnt_q  <= ecnt_d;
        end
    end

    // array is never reset; a write caught by reset is dropped
    always_ff @(posedge clk_i) begin
        if (fin & wr_q & ~bad_q & ~rst_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (mask_q[i])
                    mem_q[off_q[AW-1:LB]][8*i+:8] <= bus.HWDATA_i[8*i+:8];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bus.HBURST_i, bus.HTRANS_i[0], off_full[31:AW],
                         dbg_addr_i[31:AW], dbg_addr_i[LB-1:0]};

endmodule
